// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
//
// Purpose:
//   Shared constants and types for the pipeline inter-stage registers.
//   Holds the stall bus polarity (Stop/NotStop), the stall bus width,
//   the stage index constants along the bus, the NOP payload encodings
//   used at each stage boundary, the per-cycle action encoding and the
//   helper that turns flush/stall inputs into that action.
//
// Contents:
//   STOP / NOT_STOP      stall bus bit values
//   STALL_BUS_W          width of the central stall bus
//   STG_IF .. STG_WB     stage indices on the stall bus
//   NOP_*                NOP payloads per boundary
//   stage_action_e       FLUSH / BUBBLE / ADVANCE / HOLD
//   stage_status_t       registered valid + bubble flags
//   decode_action()      priority decode of flush/up/dn
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    localparam int STALL_BUS_W = 6;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // All boundaries currently use an all-zero payload as their NOP; they are
    // kept separate so a boundary can switch to a real NOP instruction word.
    localparam logic [31:0] NOP_IF_ID  = 32'h0000_0000;
    localparam logic [31:0] NOP_ID_EX  = 32'h0000_0000;
    localparam logic [31:0] NOP_EX_MEM = 32'h0000_0000;
    localparam logic [31:0] NOP_MEM_WB = 32'h0000_0000;

    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } stage_action_e;

    typedef struct packed {
        logic valid;
        logic bubble;
    } stage_status_t;

    // Flush beats everything; a stopped upstream with a running downstream
    // needs a bubble; a running upstream always advances (even if the
    // downstream claims to be stopped, which is a stall controller fault);
    // both stopped means hold.
    function automatic stage_action_e decode_action(input logic flush,
                                                    input logic up,
                                                    input logic dn);
        stage_action_e act;
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (up == STOP && dn == NOT_STOP) begin
            act = ACT_BUBBLE;
        end else if (up == NOT_STOP) begin
            act = ACT_ADVANCE;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
//
// Purpose:
//   Bundles the stall bus, flush and the upstream/downstream payload of one
//   pipeline boundary so the stage register and its driver share a single
//   port.
//
// Signals:
//   stall       STALL_W  central stall bus, 1 = Stop
//   flush       1        discard stage contents
//   in_valid    1        upstream payload valid
//   in_data     W        upstream payload
//   out_valid   1        registered valid
//   out_data    W        registered payload
//   out_bubble  1        registered contents are an inserted bubble
//
// Modports:
//   master      pipeline control / upstream side (drives stall, flush, in_*)
//   slave       the stage register (drives out_*)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int W       = 32,
    parameter int STALL_W = STALL_BUS_W
);

    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [W-1:0]       in_data;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic               out_bubble;

    modport master (
        output stall,
        output flush,
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  out_bubble
    );

    modport slave (
        input  stall,
        input  flush,
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output out_bubble
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_sat_counter
//
// Purpose:
//   Saturating up counter used for the stage performance counters. Stops at
//   all-ones instead of wrapping; a synchronous clear wins over an increment
//   in the same cycle.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-low reset
//   clr    in   1      synchronous clear
//   inc    in   1      increment request
//   q      out  CNT_W  current count
// ---------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;

    // Clear first, then increment only while below the saturation value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Captures a W-bit payload plus valid bit and reacts to the central stall
//   bus: advance, hold, bubble insertion (with per-bit pass/keep masks) and
//   flush. Keeps saturating counters of hold cycles and inserted bubbles.
//   All outputs are registered; there is no combinational input-to-output
//   path.
//
// Parameters:
//   W          payload width
//   STALL_W    stall bus width
//   STAGE      upstream stage index on the stall bus (downstream = STAGE+1)
//   NOP_VALUE  payload loaded on reset / flush / bubble for unmasked bits
//   PASS_MASK  bits that take in_data on a bubble
//   KEEP_MASK  bits that hold their value on a bubble (PASS wins on overlap)
//   CNT_W      performance counter width
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-low reset
//   cnt_clr     in   1      synchronous clear of both perf counters
//   bus         slave      stall/flush/in_*/out_* bundle
//   stall_cnt   out  CNT_W  cycles spent holding
//   bubble_cnt  out  CNT_W  bubbles inserted
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int           W         = 32,
    parameter int           STALL_W   = STALL_BUS_W,
    parameter int           STAGE     = STG_EX,
    parameter logic [W-1:0] NOP_VALUE = '0,
    parameter logic [W-1:0] PASS_MASK = '0,
    parameter logic [W-1:0] KEEP_MASK = '0,
    parameter int           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    generate
        if (W < 1) begin : g_bad_width
            $error("pipe_stage_reg: W must be at least 1");
        end
        if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE+1 must index inside the stall bus");
        end
    endgenerate

    // Keep bits only count where PASS does not already claim the bit; the
    // remaining bits fall back to the NOP pattern during a bubble.
    localparam logic [W-1:0] KEEP_ONLY = KEEP_MASK & ~PASS_MASK;
    localparam logic [W-1:0] NOP_BITS  = ~(PASS_MASK | KEEP_MASK);

    logic          up;
    logic          dn;
    stage_action_e action;
    logic [W-1:0]  data_q;
    stage_status_t status_q;
    logic [W-1:0]  bubble_data;

    assign up     = bus.stall[STAGE];
    assign dn     = bus.stall[STAGE+1];
    assign action = decode_action(bus.flush, up, dn);

    assign bubble_data = (bus.in_data & PASS_MASK)
                       | (data_q      & KEEP_ONLY)
                       | (NOP_VALUE   & NOP_BITS);

    // Payload and status register; HOLD simply leaves everything in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q          <= NOP_VALUE;
            status_q.valid  <= 1'b0;
            status_q.bubble <= 1'b0;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    data_q          <= NOP_VALUE;
                    status_q.valid  <= 1'b0;
                    status_q.bubble <= 1'b0;
                end
                ACT_BUBBLE: begin
                    data_q          <= bubble_data;
                    status_q.valid  <= 1'b0;
                    status_q.bubble <= 1'b1;
                end
                ACT_ADVANCE: begin
                    data_q          <= bus.in_data;
                    status_q.valid  <= bus.in_valid;
                    status_q.bubble <= 1'b0;
                end
                default: begin
                    data_q   <= data_q;
                    status_q <= status_q;
                end
            endcase
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = status_q.valid;
    assign bus.out_bubble = status_q.bubble;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (action == ACT_HOLD),
        .q   (stall_cnt)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (action == ACT_BUBBLE),
        .q   (bubble_cnt)
    );

endmodule
